ram_2r2w_arbiter: RTL and testbench

- Round-robin arbiter sharing the 2-read/2-write RAM block between NUM_REQ requesters.
- Each cycle grants up to two reads (RAM read ports 1/2) and up to two writes (RAM write ports 1/2).
- Returns read data to the owning requester with a tag-free valid pulse.
- Resolves same-cycle write-write address collisions.
- Sits between the core's load/store and fetch clients and the shared RAM instance.

---
 rtl/ram_2r2w_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_ram_2r2w_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_2r2w_arbiter.sv
// Round-robin arbiter sharing a 2-read/2-write RAM between NUM_REQ requesters.
// Optional same-cycle write-to-read bypass is compiled in with RAM_ARB_BYPASS_EN.
module ram_2r2w_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_SIZE      = 16,
  parameter int RAM_DEPTH_LOG2 = 5
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ*RAM_DEPTH_LOG2-1:0] req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                req_grant,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_SIZE-1:0]              rsp_rdata,
  output logic [DATA_SIZE-1:0]              rsp_rdata2,
  output logic                              ram_rden1,
  output logic                              ram_rden2,
  output logic                              ram_wren1,
  output logic                              ram_wren2,
  output logic [RAM_DEPTH_LOG2-1:0]         ram_addr1rd,
  output logic [RAM_DEPTH_LOG2-1:0]         ram_addr2rd,
  output logic [RAM_DEPTH_LOG2-1:0]         ram_addr1wr,
  output logic [RAM_DEPTH_LOG2-1:0]         ram_addr2wr,
  output logic [DATA_SIZE-1:0]              ram_din1,
  output logic [DATA_SIZE-1:0]              ram_din2,
  input  logic [DATA_SIZE-1:0]              ram_dout1,
  input  logic [DATA_SIZE-1:0]              ram_dout2
);

  localparam int AW    = RAM_DEPTH_LOG2;
  localparam int DW    = DATA_SIZE;
  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]    addr_a   [NUM_REQ];
  logic [DW-1:0]    wdata_a  [NUM_REQ];
  logic [IDX_W-1:0] scan_idx [NUM_REQ];

  // scan_idx[j] is the requester examined at scan position j this cycle
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      logic [IDX_W:0] scan_sum;
      assign addr_a[gi]   = req_addr[gi*AW +: AW];
      assign wdata_a[gi]  = req_wdata[gi*DW +: DW];
      assign scan_sum     = {1'b0, rr_ptr_q} + (IDX_W+1)'(gi);
      assign scan_idx[gi] = (scan_sum >= NREQ_W) ? IDX_W'(scan_sum - NREQ_W)
                                                 : scan_sum[IDX_W-1:0];
    end
  endgenerate

  logic             rd1_hit, rd2_hit, wr1_hit, wr2_hit;
  logic [IDX_W-1:0] rd1_idx, rd2_idx, wr1_idx, wr2_idx;
  logic [IDX_W-1:0] last_pos;
  logic [IDX_W-1:0] cur;

  always_comb begin
    rd1_hit  = 1'b0;
    rd2_hit  = 1'b0;
    wr1_hit  = 1'b0;
    wr2_hit  = 1'b0;
    rd1_idx  = '0;
    rd2_idx  = '0;
    wr1_idx  = '0;
    wr2_idx  = '0;
    last_pos = '0;
    cur      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cur = scan_idx[j];
      if (req_valid[cur] && !req_we[cur]) begin
        if (!rd1_hit) begin
          rd1_hit  = 1'b1;
          rd1_idx  = cur;
          last_pos = IDX_W'(j);
        end else if (!rd2_hit) begin
          rd2_hit  = 1'b1;
          rd2_idx  = cur;
          last_pos = IDX_W'(j);
        end
      end
      // a later writer aimed at port 1's address is skipped, not merged
      if (req_valid[cur] && req_we[cur]) begin
        if (!wr1_hit) begin
          wr1_hit  = 1'b1;
          wr1_idx  = cur;
          last_pos = IDX_W'(j);
        end else if (!wr2_hit && (addr_a[cur] != addr_a[wr1_idx])) begin
          wr2_hit  = 1'b1;
          wr2_idx  = cur;
          last_pos = IDX_W'(j);
        end
      end
    end
  end

  logic rd1_go, rd2_go, wr1_go, wr2_go;
  assign rd1_go = reset_n & rd1_hit;
  assign rd2_go = reset_n & rd2_hit;
  assign wr1_go = reset_n & wr1_hit;
  assign wr2_go = reset_n & wr2_hit;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign req_grant[gi] = (rd1_go && (rd1_idx == IDX_W'(gi))) |
                             (rd2_go && (rd2_idx == IDX_W'(gi))) |
                             (wr1_go && (wr1_idx == IDX_W'(gi))) |
                             (wr2_go && (wr2_idx == IDX_W'(gi)));
    end
  endgenerate

  assign ram_rden1   = rd1_go;
  assign ram_rden2   = rd2_go;
  assign ram_wren1   = wr1_go;
  assign ram_wren2   = wr2_go;
  assign ram_addr1rd = rd1_go ? addr_a[rd1_idx]  : '0;
  assign ram_addr2rd = rd2_go ? addr_a[rd2_idx]  : '0;
  assign ram_addr1wr = wr1_go ? addr_a[wr1_idx]  : '0;
  assign ram_addr2wr = wr2_go ? addr_a[wr2_idx]  : '0;
  assign ram_din1    = wr1_go ? wdata_a[wr1_idx] : '0;
  assign ram_din2    = wr2_go ? wdata_a[wr2_idx] : '0;

  // sum stays below 2*NUM_REQ, so a single conditional subtract is the modulo
  logic [IDX_W:0] ptr_sum;
  assign ptr_sum = {1'b0, rr_ptr_q} + {1'b0, last_pos} + (IDX_W+1)'(1);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (rd1_go || wr1_go) begin
      rr_ptr_d = (ptr_sum >= NREQ_W) ? IDX_W'(ptr_sum - NREQ_W) : ptr_sum[IDX_W-1:0];
    end
  end

  logic             lane1_vld_q, lane1_vld_d, lane2_vld_q, lane2_vld_d;
  logic [IDX_W-1:0] lane1_own_q, lane1_own_d, lane2_own_q, lane2_own_d;

  always_comb begin
    lane1_vld_d = rd1_go;
    lane2_vld_d = rd2_go;
    lane1_own_d = rd1_idx;
    lane2_own_d = rd2_idx;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      lane1_vld_q <= 1'b0;
      lane2_vld_q <= 1'b0;
      lane1_own_q <= '0;
      lane2_own_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lane1_vld_q <= lane1_vld_d;
      lane2_vld_q <= lane2_vld_d;
      lane1_own_q <= lane1_own_d;
      lane2_own_q <= lane2_own_d;
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = (lane1_vld_q && (lane1_own_q == IDX_W'(gi))) |
                             (lane2_vld_q && (lane2_own_q == IDX_W'(gi)));
    end
  endgenerate

`ifdef RAM_ARB_BYPASS_EN
  logic          byp1_q, byp1_d, byp2_q, byp2_d;
  logic [DW-1:0] byp1_data_q, byp1_data_d, byp2_data_q, byp2_data_d;

  // port 1 write takes precedence when both ports hit the read address
  always_comb begin
    byp1_d      = 1'b0;
    byp2_d      = 1'b0;
    byp1_data_d = '0;
    byp2_data_d = '0;
    if (rd1_go) begin
      if (wr1_go && (addr_a[wr1_idx] == addr_a[rd1_idx])) begin
        byp1_d      = 1'b1;
        byp1_data_d = wdata_a[wr1_idx];
      end else if (wr2_go && (addr_a[wr2_idx] == addr_a[rd1_idx])) begin
        byp1_d      = 1'b1;
        byp1_data_d = wdata_a[wr2_idx];
      end
    end
    if (rd2_go) begin
      if (wr1_go && (addr_a[wr1_idx] == addr_a[rd2_idx])) begin
        byp2_d      = 1'b1;
        byp2_data_d = wdata_a[wr1_idx];
      end else if (wr2_go && (addr_a[wr2_idx] == addr_a[rd2_idx])) begin
        byp2_d      = 1'b1;
        byp2_data_d = wdata_a[wr2_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp1_data_q <= '0;
      byp2_data_q <= '0;
    end else begin
      byp1_q      <= byp1_d;
      byp2_q      <= byp2_d;
      byp1_data_q <= byp1_data_d;
      byp2_data_q <= byp2_data_d;
    end
  end

  assign rsp_rdata  = !lane1_vld_q ? '0 : (byp1_q ? byp1_data_q : ram_dout1);
  assign rsp_rdata2 = !lane2_vld_q ? '0 : (byp2_q ? byp2_data_q : ram_dout2);
`else
  assign rsp_rdata  = lane1_vld_q ? ram_dout1 : '0;
  assign rsp_rdata2 = lane2_vld_q ? ram_dout2 : '0;
`endif

endmodule

// File: tb/tb_ram_2r2w_arbiter.sv
// Bench for ram_2r2w_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue-based arbitration model and a reference memory image.
module tb_ram_2r2w_arbiter;
  localparam int NR    = 4;
  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_grant, rsp_valid;
  logic [DW-1:0]     rsp_rdata, rsp_rdata2;
  logic              ram_rden1, ram_rden2, ram_wren1, ram_wren2;
  logic [AW-1:0]     ram_addr1rd, ram_addr2rd, ram_addr1wr, ram_addr2wr;
  logic [DW-1:0]     ram_din1, ram_din2;
  logic [DW-1:0]     ram_dout1, ram_dout2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_2r2w_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .RAM_DEPTH_LOG2(AW)) dut (
    .clock(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rdata2(rsp_rdata2),
    .ram_rden1(ram_rden1), .ram_rden2(ram_rden2), .ram_wren1(ram_wren1), .ram_wren2(ram_wren2),
    .ram_addr1rd(ram_addr1rd), .ram_addr2rd(ram_addr2rd),
    .ram_addr1wr(ram_addr1wr), .ram_addr2wr(ram_addr2wr),
    .ram_din1(ram_din1), .ram_din2(ram_din2),
    .ram_dout1(ram_dout1), .ram_dout2(ram_dout2)
  );

  // Shared RAM: registered read, read-before-write, cleared on the first edge
  logic [DW-1:0] ram_mem [DEPTH];
  bit ram_cleared = 1'b0;
  always @(posedge clk) begin
    if (!ram_cleared) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
      ram_dout1   <= '0;
      ram_dout2   <= '0;
      ram_cleared <= 1'b1;
    end else begin
      if (ram_rden1) ram_dout1 <= ram_mem[ram_addr1rd];
      if (ram_rden2) ram_dout2 <= ram_mem[ram_addr2rd];
      if (ram_wren2) ram_mem[ram_addr2wr] <= ram_din2;
      if (ram_wren1) ram_mem[ram_addr1wr] <= ram_din1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int k);
    return req_addr[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int k);
    return req_wdata[k*DW +: DW];
  endfunction

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            model_init = 1'b0;
  bit            exp_known = 1'b0;
  int            m_ptr = 0;
  logic [NR-1:0] exp_rsp_valid = '0;
  bit            exp_l1 = 1'b0, exp_l2 = 1'b0;
  logic [DW-1:0] exp_d1 = '0, exp_d2 = '0;
  logic [NR-1:0] model_gnt = '0;
  int            rq[$];
  int            wq[$];
  int            m_sel[4];
  int            m_idx, m_last, m_pos;
  logic [NR-1:0] g;
  int            cyc = 0;

  function automatic logic [DW-1:0] read_val(input int rd, input int w1, input int w2);
    logic [DW-1:0] v;
    v = ref_mem[addr_of(rd)];
`ifdef RAM_ARB_BYPASS_EN
    if (w2 >= 0 && addr_of(w2) == addr_of(rd)) v = wdata_of(w2);
    if (w1 >= 0 && addr_of(w1) == addr_of(rd)) v = wdata_of(w1);
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!model_init) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      model_init = 1'b1;
    end
    if (exp_known) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_valid));
      if (exp_l1) chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_d1));
      if (exp_l2) chk("rsp_rdata2", 64'(rsp_rdata2), 64'(exp_d2));
    end
    if (!reset_n) begin
      chk("grant_in_reset", 64'(req_grant), 64'(0));
      chk("en_in_reset", 64'({ram_rden1, ram_rden2, ram_wren1, ram_wren2}), 64'(0));
      m_ptr = 0;
      exp_rsp_valid = '0;
      exp_l1 = 1'b0;
      exp_l2 = 1'b0;
      exp_known = 1'b1;
      model_gnt = '0;
    end else begin
      rq.delete();
      wq.delete();
      for (int j = 0; j < NR; j++) begin
        m_idx = (m_ptr + j) % NR;
        if (req_valid[m_idx]) begin
          if (req_we[m_idx]) wq.push_back(m_idx);
          else rq.push_back(m_idx);
        end
      end
      m_sel[0] = (rq.size() > 0) ? rq[0] : -1;
      m_sel[1] = (rq.size() > 1) ? rq[1] : -1;
      m_sel[2] = (wq.size() > 0) ? wq[0] : -1;
      m_sel[3] = -1;
      for (int i = 1; i < wq.size(); i++)
        if (m_sel[3] < 0 && addr_of(wq[i]) != addr_of(m_sel[2])) m_sel[3] = wq[i];
      g = '0;
      m_last = -1;
      for (int i = 0; i < 4; i++) begin
        if (m_sel[i] >= 0) begin
          g[m_sel[i]] = 1'b1;
          m_pos = (m_sel[i] - m_ptr + NR) % NR;
          if (m_pos > m_last) m_last = m_pos;
        end
      end
      chk("req_grant", 64'(req_grant), 64'(g));
      chk("ram_rden1", 64'(ram_rden1), 64'(m_sel[0] >= 0));
      chk("ram_rden2", 64'(ram_rden2), 64'(m_sel[1] >= 0));
      chk("ram_wren1", 64'(ram_wren1), 64'(m_sel[2] >= 0));
      chk("ram_wren2", 64'(ram_wren2), 64'(m_sel[3] >= 0));
      if (m_sel[0] >= 0) chk("ram_addr1rd", 64'(ram_addr1rd), 64'(addr_of(m_sel[0])));
      if (m_sel[1] >= 0) chk("ram_addr2rd", 64'(ram_addr2rd), 64'(addr_of(m_sel[1])));
      if (m_sel[2] >= 0) begin
        chk("ram_addr1wr", 64'(ram_addr1wr), 64'(addr_of(m_sel[2])));
        chk("ram_din1", 64'(ram_din1), 64'(wdata_of(m_sel[2])));
      end
      if (m_sel[3] >= 0) begin
        chk("ram_addr2wr", 64'(ram_addr2wr), 64'(addr_of(m_sel[3])));
        chk("ram_din2", 64'(ram_din2), 64'(wdata_of(m_sel[3])));
      end
      exp_rsp_valid = '0;
      exp_l1 = (m_sel[0] >= 0);
      exp_l2 = (m_sel[1] >= 0);
      if (exp_l1) begin
        exp_rsp_valid[m_sel[0]] = 1'b1;
        exp_d1 = read_val(m_sel[0], m_sel[2], m_sel[3]);
      end
      if (exp_l2) begin
        exp_rsp_valid[m_sel[1]] = 1'b1;
        exp_d2 = read_val(m_sel[1], m_sel[2], m_sel[3]);
      end
      if (m_sel[3] >= 0) ref_mem[addr_of(m_sel[3])] = wdata_of(m_sel[3]);
      if (m_sel[2] >= 0) ref_mem[addr_of(m_sel[2])] = wdata_of(m_sel[2]);
      if (m_last >= 0) m_ptr = (m_ptr + m_last + 1) % NR;
      model_gnt = g;
      exp_known = 1'b1;
      if (g != '0)
        $display("cyc %0d grant=%b rd1=%0d rd2=%0d wr1=%0d wr2=%0d", cyc, g,
                 m_sel[0], m_sel[1], m_sel[2], m_sel[3]);
    end
  end

  task automatic step(input logic rn, input logic [NR-1:0] v, input logic [NR-1:0] we,
                      input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d);
    @(posedge clk);
    #1;
    reset_n   = rn;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #2;
  endtask

  bit [NR-1:0] pend = '0;
  int          waitc[NR];
  int          max_wait = 0;

  initial begin
    for (int k = 0; k < NR; k++) waitc[k] = 0;
    repeat (3) step(1'b0, '0, '0, '0, '0);
    chk("rst_grant", 64'(req_grant), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_rdata2", 64'(rsp_rdata2), 64'(0));

    step(1'b1, 4'b1111, 4'b0000, {5'd4, 5'd3, 5'd2, 5'd1}, '0);
    chk("a_grant", 64'(req_grant), 64'(4'b0011));
    chk("a_addr1rd", 64'(ram_addr1rd), 64'(1));
    chk("a_addr2rd", 64'(ram_addr2rd), 64'(2));
    step(1'b1, 4'b1111, 4'b0000, {5'd4, 5'd3, 5'd2, 5'd1}, '0);
    chk("b_grant", 64'(req_grant), 64'(4'b1100));
    chk("b_rsp_valid", 64'(rsp_valid), 64'(4'b0011));
    chk("b_addr1rd", 64'(ram_addr1rd), 64'(3));
    step(1'b1, 4'b1111, 4'b0000, {5'd4, 5'd3, 5'd2, 5'd1}, '0);
    chk("c_grant_wrap", 64'(req_grant), 64'(4'b0011));
    chk("c_rsp_valid", 64'(rsp_valid), 64'(4'b1100));
    step(1'b1, '0, '0, '0, '0);

    step(1'b1, 4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {16'h0, 16'h0, 16'h0, 16'hBEEF});
    chk("e_grant", 64'(req_grant), 64'(4'b0001));
    chk("e_addr1wr", 64'(ram_addr1wr), 64'(5));
    chk("e_din1", 64'(ram_din1), 64'(16'hBEEF));
    step(1'b1, 4'b0010, 4'b0000, {5'd0, 5'd0, 5'd5, 5'd0}, '0);
    chk("f_grant", 64'(req_grant), 64'(4'b0010));
    step(1'b1, 4'b1000, 4'b0000, '0, '0);
    chk("g_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("g_rsp_rdata", 64'(rsp_rdata), 64'(16'hBEEF));

    step(1'b1, 4'b0101, 4'b0101, {5'd0, 5'd7, 5'd0, 5'd7}, {16'h0, 16'h2222, 16'h0, 16'h1111});
    chk("h_collision_grant", 64'(req_grant), 64'(4'b0001));
    chk("h_wren2", 64'(ram_wren2), 64'(0));
    step(1'b1, 4'b0100, 4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, {16'h0, 16'h2222, 16'h0, 16'h0});
    chk("i_grant", 64'(req_grant), 64'(4'b0100));
    step(1'b1, 4'b1000, 4'b0000, {5'd7, 5'd0, 5'd0, 5'd0}, '0);
    chk("j_grant", 64'(req_grant), 64'(4'b1000));

    step(1'b1, 4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {16'h0, 16'h0, 16'h0, 16'h0055});
    chk("k_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
    chk("k_mem7", 64'(rsp_rdata), 64'(16'h2222));
    step(1'b1, 4'b0110, 4'b0010, {5'd0, 5'd3, 5'd3, 5'd0}, {16'h0, 16'h0, 16'h00AA, 16'h0});
    chk("l_grant", 64'(req_grant), 64'(4'b0110));
    step(1'b1, 4'b1000, 4'b0000, '0, '0);
    chk("m_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
`ifdef RAM_ARB_BYPASS_EN
    chk("m_raw_bypass", 64'(rsp_rdata), 64'(16'h00AA));
`else
    chk("m_raw_old", 64'(rsp_rdata), 64'(16'h0055));
`endif

    step(1'b1, 4'b1111, 4'b0001, '0, {16'h0, 16'h0, 16'h0, 16'h1234});
    chk("n_mixed_grant", 64'(req_grant), 64'(4'b0111));
    step(1'b1, 4'b1000, 4'b0000, '0, '0);
    chk("o_grant", 64'(req_grant), 64'(4'b1000));
    chk("o_rsp_valid", 64'(rsp_valid), 64'(4'b0110));
    step(1'b1, 4'b0010, 4'b0000, '0, '0);
    chk("p_grant", 64'(req_grant), 64'(4'b0010));

    step(1'b0, 4'b0010, 4'b0000, '0, '0);
    chk("q_grant_rst", 64'(req_grant), 64'(0));
    chk("q_rden1_rst", 64'(ram_rden1), 64'(0));
    step(1'b0, '0, '0, '0, '0);
    chk("r_rsp_valid", 64'(rsp_valid), 64'(0));
    step(1'b1, 4'b1111, 4'b0000, '0, '0);
    chk("s_ptr_reset", 64'(req_grant), 64'(4'b0011));
    step(1'b1, '0, '0, '0, '0);

    for (int c = 0; c < 150; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (pend[k] && model_gnt[k]) pend[k] = 1'b0;
        if (pend[k]) begin
          waitc[k]++;
          if (waitc[k] > max_wait) max_wait = waitc[k];
        end else begin
          waitc[k] = 0;
          if ($urandom_range(2) != 0) begin
            pend[k] = 1'b1;
            req_we[k] = 1'($urandom_range(1));
            req_addr[k*AW +: AW] = AW'($urandom_range(7));
            req_wdata[k*DW +: DW] = DW'($urandom);
          end
        end
        req_valid[k] = pend[k];
      end
    end
    step(1'b1, '0, '0, '0, '0);
    step(1'b1, '0, '0, '0, '0);
    chk("no_starvation", 64'(max_wait < 40), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
